// File: rtl/mul_pkg.sv
// mul_pkg: shared FSM state type, default operand width and integer condition code
// bit positions for the iterative multiplier.
package mul_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, FIX} mul_state_t;
    localparam int MUL_WIDTH = 32;
    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_V = 1;
    localparam int ICC_C = 0;
endpackage

// File: rtl/twos_negate.sv
// twos_negate: combinational conditional two's-complement negation, used for operand
// magnitudes and for the final sign correction of the product.
module twos_negate #(
    parameter int W = 32
) (
    input  logic         en_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);
    assign y_o = en_i ? -x_i : x_i;
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add UMUL/SMUL with start/busy/done handshake and icc flags.
// Define EARLY_TERMINATE_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 icc_n,
    output logic                 icc_z,
    output logic                 icc_v,
    output logic                 icc_c
);
    mul_state_t           state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d, mcand_q, mcand_d, product_q, product_d, res;
    logic [WIDTH-1:0]     mplier_q, mplier_d, a_mag, b_mag;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [3:0]           icc_q, icc_d;
    logic                 neg_q, neg_d, done_q, done_d;

    twos_negate #(.W(WIDTH)) u_neg_a (.en_i(signed_mode & a[WIDTH-1]), .x_i(a), .y_o(a_mag));
    twos_negate #(.W(WIDTH)) u_neg_b (.en_i(signed_mode & b[WIDTH-1]), .x_i(b), .y_o(b_mag));
    twos_negate #(.W(2*WIDTH)) u_neg_p (.en_i(neg_q), .x_i(acc_q), .y_o(res));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
            icc_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            product_q <= product_d;
            icc_q     <= icc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        product_d = product_q;
        icc_d     = icc_q;
        case (state_q)
            IDLE: if (start) begin
                acc_d    = '0;
                mcand_d  = {{WIDTH{1'b0}}, a_mag};
                mplier_d = b_mag;
                cnt_d    = CNT_W'(WIDTH);
                neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                state_d  = BUSY;
            end
            BUSY: begin
                acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CNT_W'(1);
`ifdef EARLY_TERMINATE_EN
                state_d  = (cnt_d == '0 || mplier_d == '0) ? FIX : BUSY;
`else
                state_d  = (cnt_d == '0) ? FIX : BUSY;
`endif
            end
            FIX: begin
                product_d    = res;
                icc_d[ICC_N] = res[WIDTH-1];
                icc_d[ICC_Z] = ~|res[WIDTH-1:0];
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // V and C are architecturally zero for the multiply instructions
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign product = product_q;
    assign icc_n   = icc_q[ICC_N];
    assign icc_z   = icc_q[ICC_Z];
    assign icc_v   = 1'b0;
    assign icc_c   = 1'b0;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed scoreboard bench for seq_multiplier (WIDTH=32); expected
// products come from a plain multiply model, latencies from the operand's magnitude.
module tb_seq_multiplier;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, signed_mode = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, icc_n, icc_z, icc_v, icc_c;
    logic [63:0] product;
    logic [63:0] sb[$];
    int          lat_q[$];
    int          total = 0, bad = 0;
    logic [63:0] last;

    seq_multiplier dut (
        .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
        .busy(busy), .done(done), .product(product), .icc_n(icc_n), .icc_z(icc_z),
        .icc_v(icc_v), .icc_c(icc_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic sm, input logic [31:0] av, input logic [31:0] bv);
        logic signed [63:0] sa, sbv;
        logic [31:0] bm;
        int lat;
        sa  = $signed({{32{av[31]}}, av});
        sbv = $signed({{32{bv[31]}}, bv});
        sb.push_back(sm ? 64'(sa * sbv) : {32'b0, av} * {32'b0, bv});
        bm = (sm && bv[31]) ? -bv : bv;
`ifdef EARLY_TERMINATE_EN
        lat = 2;
        for (int i = 0; i < 32; i++) if (bm[i]) lat = i + 2;
`else
        lat = 33 + 0 * int'(bm[0]);
`endif
        lat_q.push_back(lat);
        start = 1'b1;
        signed_mode = sm;
        a = av;
        b = bv;
    endtask

    task automatic wait_done(input string tag, input logic hold);
        int n, bc, lat;
        logic [63:0] e;
        n = 0;
        bc = 0;
        @(posedge clk);
        #1;
        if (hold) begin
            a = ~a;
            b = b + 32'd3;
            signed_mode = ~signed_mode;
        end else start = 1'b0;
        while (!done && n < 100) begin
            if (busy) bc++;
            if (hold) a = a + 32'h1111;
            @(posedge clk);
            #1;
            n++;
        end
        if (hold) start = 1'b0;
        e = sb.pop_front();
        lat = lat_q.pop_front();
        last = e;
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        chk({tag, "_busycyc"}, 64'(bc), 64'(lat));
        chk({tag, "_prod"}, product, e);
        chk({tag, "_n"}, 64'(icc_n), 64'(e[31]));
        chk({tag, "_z"}, 64'(icc_z), 64'(e[31:0] == 32'd0));
        chk({tag, "_busy0"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_prod", product, 64'd0);
        chk("rst_n", 64'(icc_n), 64'd0);
        chk("rst_z", 64'(icc_z), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        @(negedge clk); launch(1'b0, 32'd3, 32'd5);                 wait_done("u3x5", 1'b0);
        chk("u3x5_val", product, 64'h0000_0000_0000_000F);
        chk("icc_v", 64'(icc_v), 64'd0);
        chk("icc_c", 64'(icc_c), 64'd0);
        @(negedge clk); launch(1'b1, 32'hFFFF_FFFD, 32'd5);         wait_done("sm3x5", 1'b0);
        chk("sm3x5_val", product, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clk); launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("umax", 1'b0);
        chk("umax_val", product, 64'hFFFF_FFFE_0000_0001);
        @(negedge clk); launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done("smax", 1'b0);
        chk("smax_val", product, 64'd1);
        @(negedge clk); launch(1'b1, 32'h8000_0000, 32'h8000_0000); wait_done("sminsq", 1'b0);
        chk("sminsq_val", product, 64'h4000_0000_0000_0000);
        @(negedge clk); launch(1'b0, 32'h0001_0000, 32'h0001_0000); wait_done("z16", 1'b0);
        chk("z16_val", product, 64'h0000_0001_0000_0000);
        chk("z16_zflag", 64'(icc_z), 64'd1);

        // start held high while operands change underneath
        @(negedge clk); launch(1'b0, 32'h0000_1234, 32'h0000_0055); wait_done("hold", 1'b1);
        repeat (3) @(negedge clk);
        chk("hold_keep", product, last);
        chk("hold_idle", 64'(busy), 64'd0);

        // second start raised in the very cycle done is high
        @(negedge clk); launch(1'b1, 32'd7, 32'hFFFF_FFF7);         wait_done("b2b1", 1'b0);
        launch(1'b0, 32'hDEAD_BEEF, 32'h0000_0100);                 wait_done("b2b2", 1'b0);

        // reset in the middle of an operation
        @(negedge clk); launch(1'b0, 32'h1357_9BDF, 32'hFFFF_0001);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        void'(sb.pop_front());
        void'(lat_q.pop_front());
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_prod", product, 64'd0);
        chk("midrst_n", 64'(icc_n), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("midrst_nodone", 64'(seen), 64'd0);

        @(negedge clk); launch(1'b0, 32'd7, 32'd2);                 wait_done("e7x2", 1'b0);
        chk("e7x2_val", product, 64'd14);
        @(negedge clk); launch(1'b0, 32'h1234_5678, 32'd0);         wait_done("bzero", 1'b0);
        chk("bzero_val", product, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
